// File: rtl/cond_branch_unit_if.sv
// Branch-unit bundle: ALU flag inputs, the branch request handshake and the
// registered decision handshake. slave = branch unit, master = requester/consumer.
interface cond_branch_unit_if;
  logic       alu_neg;
  logic       alu_zero;
  logic       alu_ovf;
  logic       alu_cout;
  logic       set_flags;
  logic       reg_zero;
  logic       br_valid;
  logic [1:0] br_type;
  logic       br_ready;
  logic       out_valid;
  logic       out_taken;
  logic       out_ready;
  logic [3:0] flags;

  modport slave (
    input  alu_neg, alu_zero, alu_ovf, alu_cout, set_flags, reg_zero,
    input  br_valid, br_type, out_ready,
    output br_ready, out_valid, out_taken, flags
  );

  modport master (
    output alu_neg, alu_zero, alu_ovf, alu_cout, set_flags, reg_zero,
    output br_valid, br_type, out_ready,
    input  br_ready, out_valid, out_taken, flags
  );
endinterface

// File: rtl/cond_branch_unit.sv
// Conditional branch resolver: NZVC flag register with same-cycle forwarding
// and a one-entry registered decision buffer with valid/ready handshakes.
module cond_branch_unit (
  input  logic               clk,
  input  logic               reset,
  cond_branch_unit_if.slave  bus
);

  localparam int unsigned FLAG_W = 4;
  localparam int unsigned TYPE_W = 2;

  localparam logic [TYPE_W-1:0] BR_B   = 2'b00;
  localparam logic [TYPE_W-1:0] BR_CBZ = 2'b01;
  localparam logic [TYPE_W-1:0] BR_LT  = 2'b10;
  localparam logic [TYPE_W-1:0] BR_EQ  = 2'b11;

  logic [FLAG_W-1:0] r_flags;
  logic              r_out_valid;
  logic              r_out_taken;

  logic [FLAG_W-1:0] w_alu_flags;
  logic [FLAG_W-1:0] w_eval_flags;
  logic              w_br_ready;
  logic              w_accept;
  logic              w_cond;

  assign w_alu_flags  = {bus.alu_neg, bus.alu_zero, bus.alu_ovf, bus.alu_cout};
  // Flags being written this edge are visible to a branch accepted on the same edge.
  assign w_eval_flags = bus.set_flags ? w_alu_flags : r_flags;

  assign w_br_ready = !reset && (!r_out_valid || bus.out_ready);
  assign w_accept   = bus.br_valid && w_br_ready;

  always_comb begin
    w_cond = 1'b0;
    case (bus.br_type)
      BR_B:    w_cond = 1'b1;
      BR_CBZ:  w_cond = bus.reg_zero;
      BR_LT:   w_cond = w_eval_flags[3] ^ w_eval_flags[1];
      BR_EQ:   w_cond = w_eval_flags[2];
      default: w_cond = 1'b0;
    endcase
  end

  // Flag register updates independently of the branch handshake.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_flags <= FLAG_W'(0);
    end else if (bus.set_flags) begin
      r_flags <= w_alu_flags;
    end
  end

  // One-entry decision buffer: reload on accept, drain on consume, else hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_taken <= 1'b0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_taken <= w_cond;
    end else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
      r_out_taken <= 1'b0;
    end
  end

  assign bus.br_ready  = w_br_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_taken = r_out_taken;
  assign bus.flags     = r_flags;

endmodule

// File: tb/tb_cond_branch_unit.sv
// Directed bench for cond_branch_unit: inputs change and outputs are sampled
// 1 time unit after each rising edge.
module tb_cond_branch_unit;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;

  cond_branch_unit_if bus ();

  cond_branch_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic set_alu(input logic [3:0] nzvc);
    {bus.alu_neg, bus.alu_zero, bus.alu_ovf, bus.alu_cout} = nzvc;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset         = 1'b1;
    set_alu(4'b0000);
    bus.set_flags = 1'b0;
    bus.reg_zero  = 1'b0;
    bus.br_valid  = 1'b0;
    bus.br_type   = 2'b00;
    bus.out_ready = 1'b0;

    // Reset state
    tick();
    tick();
    chk("rst_flags", bus.flags, 4'b0000);
    chk("rst_out_valid", 4'(bus.out_valid), 4'd0);
    chk("rst_out_taken", 4'(bus.out_taken), 4'd0);
    chk("rst_br_ready", 4'(bus.br_ready), 4'd0);
    reset = 1'b0;
    #1;
    chk("idle_br_ready", 4'(bus.br_ready), 4'd1);

    // Flag capture, then B.LT with N=1 V=0
    set_alu(4'b1001);
    bus.set_flags = 1'b1;
    tick();
    chk("flags_1001", bus.flags, 4'b1001);
    bus.set_flags = 1'b0;
    set_alu(4'b0000);
    bus.out_ready = 1'b1;
    bus.br_valid  = 1'b1;
    bus.br_type   = 2'b10;
    tick();
    chk("blt_valid", 4'(bus.out_valid), 4'd1);
    chk("blt_taken", 4'(bus.out_taken), 4'd1);
    bus.br_valid = 1'b0;
    tick();
    chk("blt_drain_valid", 4'(bus.out_valid), 4'd0);
    chk("blt_drain_taken", 4'(bus.out_taken), 4'd0);

    // B.EQ with forwarded flags overriding stored Z=1
    set_alu(4'b0100);
    bus.set_flags = 1'b1;
    tick();
    chk("flags_0100", bus.flags, 4'b0100);
    set_alu(4'b0000);
    bus.br_valid = 1'b1;
    bus.br_type  = 2'b11;
    tick();
    chk("beq_fwd_valid", 4'(bus.out_valid), 4'd1);
    chk("beq_fwd_taken", 4'(bus.out_taken), 4'd0);
    chk("beq_fwd_flags", bus.flags, 4'b0000);

    // B.EQ using stored Z=1 while the ALU shows Z=0
    set_alu(4'b0100);
    bus.br_valid = 1'b0;
    tick();
    bus.set_flags = 1'b0;
    set_alu(4'b0000);
    bus.br_valid = 1'b1;
    tick();
    chk("beq_stored_taken", 4'(bus.out_taken), 4'd1);
    chk("beq_stored_flags", bus.flags, 4'b0100);

    // Back-to-back CBZ, reg_zero 1 then 0
    bus.br_type  = 2'b01;
    bus.reg_zero = 1'b1;
    set_alu(4'b1111);
    tick();
    chk("cbz1_valid", 4'(bus.out_valid), 4'd1);
    chk("cbz1_taken", 4'(bus.out_taken), 4'd1);
    bus.reg_zero = 1'b0;
    tick();
    chk("cbz0_valid", 4'(bus.out_valid), 4'd1);
    chk("cbz0_taken", 4'(bus.out_taken), 4'd0);
    bus.br_valid = 1'b0;
    tick();
    chk("cbz_drain_valid", 4'(bus.out_valid), 4'd0);
    chk("cbz_flags_kept", bus.flags, 4'b0100);

    // Output stall: pending B held, second request blocked, flags still update
    bus.out_ready = 1'b0;
    bus.br_valid  = 1'b1;
    bus.br_type   = 2'b00;
    tick();
    chk("stall_valid", 4'(bus.out_valid), 4'd1);
    chk("stall_taken", 4'(bus.out_taken), 4'd1);
    chk("stall_br_ready", 4'(bus.br_ready), 4'd0);
    bus.br_type  = 2'b01;
    bus.reg_zero = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.set_flags = (i == 1);
      set_alu(4'b0010);
      tick();
      chk("stall_hold_valid", 4'(bus.out_valid), 4'd1);
      chk("stall_hold_taken", 4'(bus.out_taken), 4'd1);
      chk("stall_hold_br_ready", 4'(bus.br_ready), 4'd0);
    end
    bus.set_flags = 1'b0;
    chk("stall_flags_update", bus.flags, 4'b0010);
    bus.out_ready = 1'b1;
    #1;
    chk("unstall_br_ready", 4'(bus.br_ready), 4'd1);
    tick();
    chk("second_req_valid", 4'(bus.out_valid), 4'd1);
    chk("second_req_taken", 4'(bus.out_taken), 4'd0);
    bus.br_valid = 1'b0;
    tick();
    chk("second_drain_valid", 4'(bus.out_valid), 4'd0);

    // Asynchronous reset with a decision pending
    bus.out_ready = 1'b0;
    set_alu(4'b1111);
    bus.set_flags = 1'b1;
    bus.br_valid  = 1'b1;
    bus.br_type   = 2'b00;
    tick();
    chk("pre_rst_valid", 4'(bus.out_valid), 4'd1);
    chk("pre_rst_flags", bus.flags, 4'b1111);
    bus.set_flags = 1'b0;
    bus.br_valid  = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_valid", 4'(bus.out_valid), 4'd0);
    chk("async_rst_taken", 4'(bus.out_taken), 4'd0);
    chk("async_rst_flags", bus.flags, 4'b0000);
    chk("async_rst_br_ready", 4'(bus.br_ready), 4'd0);
    tick();
    reset = 1'b0;
    #1;
    chk("post_rst_br_ready", 4'(bus.br_ready), 4'd1);
    tick();
    chk("post_rst_valid", 4'(bus.out_valid), 4'd0);

    // Idle with out_ready toggling and no set_flags
    set_alu(4'b0110);
    bus.set_flags = 1'b1;
    tick();
    bus.set_flags = 1'b0;
    set_alu(4'b1001);
    for (int i = 0; i < 4; i++) begin
      bus.out_ready = i[0];
      tick();
      chk("idle_valid", 4'(bus.out_valid), 4'd0);
      chk("idle_taken", 4'(bus.out_taken), 4'd0);
      chk("idle_flags", bus.flags, 4'b0110);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cond_branch_unit.md
COND_BRANCH_UNIT -- requirements
Module: cond_branch_unit

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 alu_neg  input  1  ALU negative result flag.
REQ-005 alu_zero  input  1  ALU zero flag, produced by the zero-detect NOR tree.
REQ-006 alu_ovf  input  1  ALU signed overflow flag.
REQ-007 alu_cout  input  1  ALU carry-out flag.
REQ-008 set_flags  input  1  high: capture alu_* into the flag register this edge.
REQ-009 reg_zero  input  1  zero-detect of the register-read operand, used by CBZ.
REQ-010 br_valid  input  1  branch request valid.
REQ-011 br_type  input  2  00 B (always), 01 CBZ, 10 B.LT, 11 B.EQ.
REQ-012 br_ready  output  1  block can accept a request this cycle.
REQ-013 out_valid  output  1  registered branch decision available.
REQ-014 out_taken  output  1  decision: 1 = take branch; meaningful only when out_valid=1.
REQ-015 out_ready  input  1  consumer accepts the decision this cycle.
REQ-016 flags  output  4  registered {N,Z,V,C}, bit 3 = N, bit 0 = C.

Function
REQ-017 The flag register SHALL load {alu_neg,alu_zero,alu_ovf,alu_cout} on an edge where set_flags=1 and SHALL otherwise hold.
REQ-018 A request SHALL be accepted on an edge where br_valid=1 and br_ready=1.
REQ-019 br_ready SHALL equal (!out_valid || out_ready) when reset=0, and SHALL be 0 while reset=1.
REQ-020 Condition evaluation: B -> 1; CBZ -> reg_zero; B.LT -> (N != V); B.EQ -> Z.
REQ-021 Flag forwarding: if set_flags=1 in the accept cycle, B.LT/B.EQ SHALL use the incoming alu_* values, not the stored flags.
REQ-022 CBZ SHALL sample reg_zero in the accept cycle and SHALL be unaffected by set_flags.
REQ-023 Latency: the decision SHALL appear on out_valid/out_taken on the edge after acceptance (1 cycle).
REQ-024 The output stage SHALL be a one-entry buffer: out_valid and out_taken SHALL hold stable while out_valid=1 and out_ready=0.
REQ-025 On an edge with out_valid=1 and out_ready=1 and no new accept, out_valid SHALL clear to 0.
REQ-026 On an edge with out_valid=1, out_ready=1 and a new accept, the buffer SHALL reload with the new decision and out_valid SHALL stay 1 (back-to-back, 1 decision per cycle).
REQ-027 br_valid=1 with br_ready=0 SHALL NOT be accepted, and the requester SHALL hold br_valid/br_type.
REQ-028 out_taken SHALL be 0 whenever out_valid=0.
REQ-029 set_flags SHALL update flags regardless of the branch handshake state, including during output stall.

Reset
REQ-030 While reset=1, flags SHALL be 4'b0000, out_valid 0, out_taken 0, br_ready 0, asynchronously, without waiting for a clk edge.
REQ-031 Reset asserted with a decision pending SHALL discard it; after deassertion the first edge SHALL behave as idle (br_ready=1).

Verification
REQ-032 Reset, then set_flags=1 with alu N,Z,V,C=1,0,0,1 -> flags=4'b1001 after one edge; B.LT request -> out_taken=1 next cycle.
REQ-033 Stored flags 4'b0100, B.EQ request with set_flags=1 and alu_zero=0 in the same cycle -> out_taken=0 (forwarded), flags=4'b0000.
REQ-034 CBZ with reg_zero=1 then CBZ with reg_zero=0, out_ready=1 throughout -> out_valid=1 for 2 consecutive cycles, out_taken 1 then 0.
REQ-035 out_ready=0 with a pending B decision -> br_ready=0, out_valid/out_taken held 3 cycles; a second request is not accepted until out_ready=1.
REQ-036 Reset asserted mid-cycle with out_valid=1 -> out_valid, out_taken, flags drop to 0 immediately, before the next clk edge.
REQ-037 Idle with br_valid=0 and out_ready toggling -> out_valid stays 0, flags unchanged.
